awgn_ctrl: RTL and testbench
============================

AWGN_CTRL -- requirements
Module: awgn_ctrl

Interface
REQ-001 Parameter WARM_CYCLES, default 16: cycles discarded after core reset release before samples are captured.
REQ-002 Parameter FIFO_DEPTH, default 4: fixed output buffer depth (power of two).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start  input  1  single-cycle request to begin a burst; honoured in IDLE only.
REQ-006 abort  input  1  terminates any active burst.
REQ-007 burst_len  input  16  samples to deliver; 0 = continuous until abort.
REQ-008 seed_in  input  192  six 32-bit seeds, seed1 in [31:0] through seed6 in [191:160].
REQ-009 core_rst  output  1  active-low reset driven to the noise core.
REQ-010 core_seed  output  192  latched seeds driven to the noise core.
REQ-011 core_sample  input  16  two's-complement sample from the core, new value every cycle.
REQ-012 sample_out  output  16  FIFO head sample.
REQ-013 sample_valid  output  1  sample_out holds valid data.
REQ-014 sample_ready  input  1  consumer accepts sample_out this cycle.
REQ-015 busy  output  1  high in every state except IDLE.
REQ-016 done  output  1  one-cycle pulse at burst completion.
REQ-017 overflow_cnt  output  16  samples dropped because the FIFO was full.

Function
REQ-018 The FSM SHALL have states IDLE, SEED, WARM, RUN and DONE.
REQ-019 In IDLE, start=1 SHALL latch seed_in to core_seed and burst_len to an internal register, clear overflow_cnt and the counters, and go to SEED.
REQ-020 SEED SHALL last exactly 2 cycles with core_rst=0, then go to WARM.
REQ-021 WARM SHALL last exactly WARM_CYCLES cycles with core_rst=1, then go to RUN; no samples are captured in WARM.
REQ-022 core_rst SHALL be 0 in IDLE and SEED, and 1 in WARM, RUN and DONE.
REQ-023 In RUN, each cycle where pushed<burst_len (or burst_len=0) SHALL push core_sample when the FIFO is not full, or when it is full and a pop occurs in the same cycle.
REQ-024 A required push blocked by a full FIFO SHALL drop the sample and increment overflow_cnt, saturating at 0xFFFF.
REQ-025 sample_valid SHALL equal (state==RUN && FIFO non-empty); a pop occurs when sample_valid && sample_ready.
REQ-026 Data SHALL leave the FIFO in arrival order, unmodified.
REQ-027 For burst_len!=0, after the burst_len-th pop RUN SHALL go to DONE; pushes stop after burst_len pushes.
REQ-028 DONE SHALL last 1 cycle with done=1, then go to IDLE.
REQ-029 abort=1 in any non-IDLE state SHALL go to IDLE next cycle, flush the FIFO and suppress done; abort has priority over every other transition; start is ignored outside IDLE.
REQ-030 A 16-bit pushed counter and a 16-bit popped counter SHALL be kept; both are unused when burst_len=0.

Reset
REQ-031 rst=1 SHALL force state IDLE, FIFO empty, counters 0, core_seed=0, core_rst=0, sample_out=0, sample_valid=0, busy=0, done=0 and overflow_cnt=0 on the next edge, including during RUN.

Verification
REQ-032 Reset, then start with burst_len=3, seed_in nonzero, sample_ready=1 -> core_rst low for cycles 1-2 after start, high from cycle 3; first sample_valid at cycle 2+16+1; 3 pops; done one cycle later; busy low after done.
REQ-033 burst_len=5, sample_ready=0 for 10 RUN cycles, then 1 -> the first 4 core samples are delivered in order; overflow_cnt=1 (5th required push dropped) and keeps counting until ready returns.
REQ-034 FIFO full, sample_ready=1 with a push in the same cycle -> no drop, FIFO count stays at 4, overflow_cnt unchanged.
REQ-035 burst_len=0, abort after 50 RUN cycles -> IDLE next cycle, sample_valid=0, FIFO empty, done never pulses.
REQ-036 rst asserted mid-RUN with 2 entries buffered -> all outputs at reset values next cycle; a following start works normally.
REQ-037 start asserted during WARM -> ignored, with WARM timing and latched seeds unchanged.

Source files
------------

// File: rtl/awgn_ctrl.sv
`default_nettype none
// ============================================================================
// awgn_ctrl : sequences seeding/warm-up of an AWGN core and buffers its samples
// Revision  : 1.0
// ============================================================================
module awgn_ctrl #(
  parameter int WARM_CYCLES = 16,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         abort,
  input  logic [15:0]  burst_len,
  input  logic [191:0] seed_in,
  output logic         core_rst,
  output logic [191:0] core_seed,
  input  logic [15:0]  core_sample,
  output logic [15:0]  sample_out,
  output logic         sample_valid,
  input  logic         sample_ready,
  output logic         busy,
  output logic         done,
  output logic [15:0]  overflow_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(WARM_CYCLES + 1) + 1;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SEED = 3'd1,
    WARM = 3'd2,
    RUN  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cyc_q, cyc_d;
  logic [191:0]   seed_q, seed_d;
  logic [15:0]    len_q, len_d;
  logic [15:0]    pushed_q, pushed_d;
  logic [15:0]    popped_q, popped_d;
  logic [15:0]    ovf_q, ovf_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic [15:0]    mem_q [FIFO_DEPTH];
  logic [15:0]    mem_d [FIFO_DEPTH];

  logic fifo_empty, fifo_full, pop, push_req, push, drop;

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == (AW+1)'(FIFO_DEPTH));
  assign pop        = sample_valid && sample_ready;
  // A push is still owed every RUN cycle until burst_len samples are stored
  assign push_req   = (state_q == RUN) && ((len_q == 16'd0) || (pushed_q < len_q));
  assign push       = push_req && (!fifo_full || pop);
  assign drop       = push_req && fifo_full && !pop;

  assign sample_valid = (state_q == RUN) && !fifo_empty;
  assign sample_out   = sample_valid ? mem_q[rd_ptr_q] : 16'd0;
  assign core_rst     = (state_q == WARM) || (state_q == RUN) || (state_q == DONE);
  assign core_seed    = seed_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE) && !abort;
  assign overflow_cnt = ovf_q;

  always_comb begin
    state_d  = state_q;
    cyc_d    = cyc_q;
    seed_d   = seed_q;
    len_d    = len_q;
    pushed_d = pushed_q;
    popped_d = popped_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (push) begin
      mem_d[wr_ptr_q] = core_sample;
      wr_ptr_d        = wr_ptr_q + AW'(1);
      pushed_d        = pushed_q + 16'd1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      popped_d = popped_q + 16'd1;
    end
    count_d = count_q + (AW+1)'(push) - (AW+1)'(pop);
    if (drop && (ovf_q != 16'hFFFF)) begin
      ovf_d = ovf_q + 16'd1;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = SEED;
          cyc_d    = '0;
          seed_d   = seed_in;
          len_d    = burst_len;
          pushed_d = 16'd0;
          popped_d = 16'd0;
          ovf_d    = 16'd0;
          wr_ptr_d = '0;
          rd_ptr_d = '0;
          count_d  = '0;
        end
      end
      SEED: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(1)) begin
          state_d = WARM;
          cyc_d   = '0;
        end
      end
      WARM: begin
        cyc_d = cyc_q + CW'(1);
        if (cyc_q == CW'(WARM_CYCLES - 1)) begin
          state_d = RUN;
          cyc_d   = '0;
        end
      end
      RUN: begin
        if ((len_q != 16'd0) && pop && ((popped_q + 16'd1) == len_q)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over every other transition and discards buffered samples
    if (abort && (state_q != IDLE)) begin
      state_d  = IDLE;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cyc_q    <= '0;
      seed_q   <= '0;
      len_q    <= 16'd0;
      pushed_q <= 16'd0;
      popped_q <= 16'd0;
      ovf_q    <= 16'd0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= 16'd0;
      end
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      seed_q   <= seed_d;
      len_q    <= len_d;
      pushed_q <= pushed_d;
      popped_q <= popped_d;
      ovf_q    <= ovf_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_awgn_ctrl.sv
`default_nettype none
// ============================================================================
// tb_awgn_ctrl : randomized bench against a queue-based burst model
// Revision     : 1.0
// ============================================================================
module tb_awgn_ctrl;

  localparam int W     = 16;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [15:0]  burst_len = 16'd0;
  logic [191:0] seed_in = '0;
  logic         core_rst;
  logic [191:0] core_seed;
  logic [15:0]  core_sample = 16'd0;
  logic [15:0]  sample_out;
  logic         sample_valid;
  logic         sample_ready = 1'b0;
  logic         busy;
  logic         done;
  logic [15:0]  overflow_cnt;

  int checks   = 0;
  int failures = 0;

  // Model: phase 0 idle, 1 seed, 2 warm, 3 run, 4 done
  int           m_ph = 0;
  int           m_t = 0;
  logic [15:0]  m_q[$];
  int           m_len = 0;
  int           m_pushed = 0;
  int           m_popped = 0;
  int           m_ovf = 0;
  logic [191:0] m_seed = '0;

  always #5 clk = ~clk;

  awgn_ctrl #(.WARM_CYCLES(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .abort        (abort),
    .burst_len    (burst_len),
    .seed_in      (seed_in),
    .core_rst     (core_rst),
    .core_seed    (core_seed),
    .core_sample  (core_sample),
    .sample_out   (sample_out),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .busy         (busy),
    .done         (done),
    .overflow_cnt (overflow_cnt)
  );

  task automatic check(input string tag, input logic [191:0] obs, input logic [191:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_step();
    bit pop, need;
    if (rst) begin
      m_ph = 0; m_t = 0; m_q.delete(); m_len = 0;
      m_pushed = 0; m_popped = 0; m_ovf = 0; m_seed = '0;
    end else if (m_ph != 0 && abort) begin
      m_ph = 0;
      m_q.delete();
    end else begin
      case (m_ph)
        0: if (start) begin
          m_seed = seed_in; m_len = int'(burst_len);
          m_ovf = 0; m_pushed = 0; m_popped = 0; m_q.delete();
          m_ph = 1; m_t = 0;
        end
        1: begin
          m_t++;
          if (m_t == 2) begin m_ph = 2; m_t = 0; end
        end
        2: begin
          m_t++;
          if (m_t == W) begin m_ph = 3; m_t = 0; end
        end
        3: begin
          pop  = (m_q.size() > 0) && sample_ready;
          need = (m_len == 0) || (m_pushed < m_len);
          if (pop) begin
            void'(m_q.pop_front());
            m_popped++;
          end
          if (need) begin
            if (m_q.size() < DEPTH) begin
              m_q.push_back(core_sample);
              m_pushed++;
            end else if (m_ovf < 65535) begin
              m_ovf++;
            end
          end
          if (m_len != 0 && pop && m_popped == m_len) m_ph = 4;
        end
        default: m_ph = 0;
      endcase
    end
  endfunction

  task automatic compare();
    bit vld;
    vld = (m_ph == 3) && (m_q.size() > 0);
    check("core_rst", 192'(core_rst), 192'(m_ph >= 2));
    check("busy", 192'(busy), 192'(m_ph != 0));
    check("done", 192'(done), 192'((m_ph == 4) && !abort));
    check("valid", 192'(sample_valid), 192'(vld));
    check("sample_out", 192'(sample_out), vld ? 192'(m_q[0]) : 192'(0));
    check("overflow", 192'(overflow_cnt), 192'(m_ovf));
    check("core_seed", core_seed, m_seed);
  endtask

  task automatic tick();
    core_sample = 16'($urandom);
    model_step();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic wait_phase(input int target, input int budget, input bit rand_ready);
    int n = 0;
    while (m_ph != target && n < budget) begin
      if (rand_ready) sample_ready = 1'($urandom);
      tick();
      n++;
    end
    check("wait_phase", 192'(m_ph), 192'(target));
  endtask

  task automatic do_start(input logic [15:0] len);
    burst_len = len;
    seed_in   = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    start     = 1'b1;
    tick();
    start     = 1'b0;
  endtask

  initial begin
    // Reset state
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Basic 3-sample burst with consumer always ready
    sample_ready = 1'b1;
    do_start(16'd3);
    wait_phase(0, 200, 1'b0);
    tick();

    // Back-pressure: 10 RUN cycles without ready, then drain
    do_start(16'd5);
    wait_phase(3, 100, 1'b0);
    sample_ready = 1'b0;
    repeat (10) tick();
    check("ovf_after_stall", 192'(overflow_cnt), 192'(6));
    sample_ready = 1'b1;
    tick();
    check("ovf_push_pop_full", 192'(overflow_cnt), 192'(6));
    wait_phase(0, 200, 1'b0);

    // Continuous burst aborted after 50 RUN cycles
    do_start(16'd0);
    wait_phase(3, 100, 1'b0);
    repeat (50) begin
      sample_ready = 1'($urandom);
      tick();
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_valid", 192'(sample_valid), 192'(0));
    repeat (3) tick();

    // Reset in the middle of RUN with two samples buffered
    sample_ready = 1'b0;
    do_start(16'd0);
    wait_phase(3, 100, 1'b0);
    repeat (2) tick();
    check("buffered_before_rst", 192'(m_q.size()), 192'(2));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_sample_out", 192'(sample_out), 192'(0));
    check("rst_busy", 192'(busy), 192'(0));
    sample_ready = 1'b1;
    do_start(16'd2);
    wait_phase(0, 200, 1'b0);

    // Start during WARM must be ignored
    do_start(16'd4);
    wait_phase(2, 10, 1'b0);
    repeat (3) tick();
    seed_in   = ~seed_in;
    burst_len = 16'd9;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    wait_phase(0, 200, 1'b1);

    // Random bursts with random back-pressure and occasional abort
    for (int b = 0; b < 8; b++) begin
      do_start(16'($urandom_range(1, 8)));
      wait_phase(3, 100, 1'b0);
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(0, 6)) begin
          sample_ready = 1'($urandom);
          tick();
        end
        abort = (m_ph != 0);
        tick();
        abort = 1'b0;
      end
      wait_phase(0, 400, 1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
